fft_frame_serializer: RTL

Parallel-to-serial converter at the output end of the FFT datapath. It accepts one complete frame in the same packed real/imag layout the FFT stage produces: `2 * N_SAMPLES` words of `BIT_WIDTH` bits in a single val/rdy transfer. It then streams the frame out one complex sample per cycle over a narrow val/rdy interface toward the magnitude and classifier logic. Sample order is natural or bit-reversed, selected by parameter.

---
 rtl/fft_frame_serializer_if.sv | 27 ++
 rtl/fft_frame_serializer.sv | 89 ++++++++
 2 files changed

// File: rtl/fft_frame_serializer_if.sv
// Handshake bundle for the FFT frame serializer: wide frame in, one complex
// sample per transfer out.
interface fft_frame_serializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  localparam int IDX_W = $clog2(N_SAMPLES);

  logic [2*BIT_WIDTH*N_SAMPLES-1:0] recv_msg;
  logic                             recv_val;
  logic                             recv_rdy;
  logic [2*BIT_WIDTH-1:0]           send_msg;
  logic [IDX_W-1:0]                 send_idx;
  logic                             send_last;
  logic                             send_val;
  logic                             send_rdy;

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_idx, send_last, send_val
  );

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_idx, send_last, send_val
  );
endinterface

// File: rtl/fft_frame_serializer.sv
// Captures one packed real/imag FFT frame and streams it out one complex
// sample per handshake, in natural or bit-reversed bin order.
//
// state   | meaning
// ST_IDLE | ready for a frame, no sample valid
// ST_SEND | presenting sample cnt (after optional bit reversal)
module fft_frame_serializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int DECIMAL_PT  = 16,
  parameter int N_SAMPLES   = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_serializer_if.slave io_bus
);
  localparam int CW = $clog2(N_SAMPLES);

  generate
    if (N_SAMPLES < 2 || N_SAMPLES > 16 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
      $error("N_SAMPLES must be a power of two in 2..16");
    end
    if (DECIMAL_PT < 0 || DECIMAL_PT > BIT_WIDTH) begin : g_bad_pt
      $error("DECIMAL_PT must lie within BIT_WIDTH");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [BIT_WIDTH-1:0] r_buf [2*N_SAMPLES];

  logic [CW-1:0] w_k;
  logic          w_send;
  logic          w_at_last;

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int b = 0; b < CW; b++) r[b] = v[CW-1-b];
    return r;
  endfunction

  assign w_k       = (BIT_REVERSE != 0) ? bitrev(r_cnt) : r_cnt;
  assign w_at_last = (r_cnt == CW'(N_SAMPLES - 1));
  // Outputs are forced quiet while reset is held, even before the first edge.
  assign w_send    = (r_state == ST_SEND) && !reset;

  assign io_bus.recv_rdy  = (r_state == ST_IDLE) && !reset;
  assign io_bus.send_val  = w_send;
  assign io_bus.send_last = w_send && w_at_last;
  assign io_bus.send_idx  = w_send ? w_k : '0;
  // N+k is just k with the top index bit set, since N is a power of two.
  assign io_bus.send_msg  = w_send ? {r_buf[{1'b1, w_k}], r_buf[{1'b0, w_k}]} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < 2*N_SAMPLES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.recv_val) begin
            for (int i = 0; i < 2*N_SAMPLES; i++)
              r_buf[i] <= io_bus.recv_msg[BIT_WIDTH*i +: BIT_WIDTH];
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (io_bus.send_rdy) begin
            if (w_at_last) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule
